// File: rtl/dffrs_pipe.sv
// Elastic register pipeline of DEPTH stages with synchronous reset/preset and
// collapsing bubbles; one beat per cycle at full rate, ready back-pressure from Q_READY.

module dffrs_pipe_stage #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter logic [WIDTH-1:0] SET_VAL   = '1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SETN,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    always_ff @(posedge CLK) begin
        if (RST)
            dout <= RESET_VAL;
        else if (!SETN)
            dout <= SET_VAL;
        else if (load)
            dout <= din;
    end
endmodule

module dffrs_pipe #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter logic [WIDTH-1:0] SET_VAL   = '1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       SETN,
    input  logic [WIDTH-1:0]           D,
    input  logic                       D_VALID,
    output logic                       D_READY,
    output logic [WIDTH-1:0]           Q,
    output logic                       Q_VALID,
    input  logic                       Q_READY,
    output logic [$clog2(DEPTH+1)-1:0] OCC
);
    localparam int OW = $clog2(DEPTH+1);

    logic [DEPTH-1:0]            vld_pipe;
    logic [DEPTH-1:0]            move;
    logic [DEPTH-1:0]            load;
    logic [DEPTH-1:0][WIDTH-1:0] data;
    logic [DEPTH-1:0][WIDTH-1:0] din;
    logic                        free;
    logic                        in_xfer;
    logic                        out_xfer;

    // Walk from the output back: a stage may move when the one ahead is empty or moving.
    always_comb begin
        move = '0;
        free = Q_READY;
        for (int k = DEPTH-1; k >= 0; k--) begin
            move[k] = vld_pipe[k] & free;
            free    = ~vld_pipe[k] | move[k];
        end
        D_READY = free;
    end

    assign in_xfer  = D_VALID & D_READY;
    assign out_xfer = Q_VALID & Q_READY;

    always_comb begin
        load    = '0;
        din     = '0;
        load[0] = in_xfer;
        din[0]  = D;
        for (int k = 1; k < DEPTH; k++) begin
            load[k] = move[k-1];
            din[k]  = data[k-1];
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        dffrs_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL),
            .SET_VAL   (SET_VAL)
        ) u_stage (
            .CLK  (CLK),
            .RST  (RST),
            .SETN (SETN),
            .load (load[k]),
            .din  (din[k]),
            .dout (data[k])
        );
    end

    always_ff @(posedge CLK) begin
        if (RST || !SETN)
            vld_pipe <= '0;
        else
            vld_pipe <= load | (vld_pipe & ~move);
    end

    // Transfers are mutually consistent with vld_pipe, so OCC stays within 0..DEPTH.
    always_ff @(posedge CLK) begin
        if (RST || !SETN)
            OCC <= '0;
        else if (in_xfer && !out_xfer)
            OCC <= OCC + OW'(1);
        else if (out_xfer && !in_xfer)
            OCC <= OCC - OW'(1);
    end

    assign Q       = data[DEPTH-1];
    assign Q_VALID = vld_pipe[DEPTH-1];
endmodule

// File: tb/tb_dffrs_pipe.sv
// Directed + randomized check of dffrs_pipe (8-bit, 3 stages) against a beat scoreboard.

module tb_dffrs_pipe;
    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       SETN = 1'b1;
    logic [7:0] D = '0;
    logic       D_VALID = 1'b0;
    logic       D_READY;
    logic [7:0] Q;
    logic       Q_VALID;
    logic       Q_READY = 1'b0;
    logic [1:0] OCC;

    int total = 0;
    int bad   = 0;
    logic [7:0] sb[$];

    dffrs_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00), .SET_VAL(8'hFF)) dut (
        .CLK(CLK), .RST(RST), .SETN(SETN), .D(D), .D_VALID(D_VALID), .D_READY(D_READY),
        .Q(Q), .Q_VALID(Q_VALID), .Q_READY(Q_READY), .OCC(OCC)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: record handshakes from the settled pre-edge values, then compare after the edge.
    task automatic cyc();
        logic       acc, emit;
        logic [7:0] exp;
        #1;
        acc  = D_VALID && D_READY && !RST && SETN;
        emit = Q_VALID && Q_READY && !RST && SETN;
        if (emit) begin
            if (sb.size() == 0) chk("emit_unexpected", {24'd0, Q}, 32'hDEAD);
            else begin
                exp = sb.pop_front();
                chk("emit_data", {24'd0, Q}, {24'd0, exp});
            end
        end
        if (acc) sb.push_back(D);
        if (RST || !SETN) sb.delete();
        @(posedge CLK);
        @(negedge CLK);
        chk("occ_vs_scoreboard", {30'd0, OCC}, sb.size());
        chk("no_x", {28'd0, $isunknown(Q), $isunknown(Q_VALID), $isunknown(OCC), $isunknown(D_READY)}, 0);
    endtask

    task automatic drain();
        int n = 0;
        D_VALID = 1'b0;
        Q_READY = 1'b1;
        while (sb.size() != 0 && n < 20) begin cyc(); n++; end
        chk("drain_bound", sb.size(), 0);
        cyc();
    endtask

    initial begin
        @(negedge CLK);
        // Reset
        RST = 1'b1; D = 8'h5A; SETN = 1'b0;
        cyc();
        RST = 1'b0; SETN = 1'b1;
        #1;
        chk("rst_q", {24'd0, Q}, 32'h00);
        chk("rst_qv", {31'd0, Q_VALID}, 0);
        chk("rst_occ", {30'd0, OCC}, 0);
        chk("rst_dready", {31'd0, D_READY}, 1);

        // Streaming 0x11, 0x22, 0x33 with Q_READY high
        Q_READY = 1'b1; D_VALID = 1'b1;
        D = 8'h11; cyc(); chk("lat_qv0", {31'd0, Q_VALID}, 0);
        D = 8'h22; cyc(); chk("lat_qv1", {31'd0, Q_VALID}, 0);
        D = 8'h33; cyc(); chk("lat_q11", {23'd0, Q_VALID, Q}, 32'h111);
        D_VALID = 1'b0;
        cyc(); chk("b2b_q22", {23'd0, Q_VALID, Q}, 32'h122);
        cyc(); chk("b2b_q33", {23'd0, Q_VALID, Q}, 32'h133);
        cyc(); chk("stream_empty", {31'd0, Q_VALID}, 0);

        // Fill with Q_READY low, then simultaneous accept and emit
        Q_READY = 1'b0; D_VALID = 1'b1;
        D = 8'hA1; cyc();
        D = 8'hA2; cyc();
        D = 8'hA3; cyc();
        D = 8'hA4; cyc();
        chk("full_occ", {30'd0, OCC}, 3);
        chk("full_dready", {31'd0, D_READY}, 0);
        chk("full_q", {23'd0, Q_VALID, Q}, 32'h1A1);
        cyc();
        chk("stall_hold", {23'd0, Q_VALID, Q}, 32'h1A1);
        Q_READY = 1'b1;
        #1 chk("full_dready_qr", {31'd0, D_READY}, 1);
        cyc();
        D_VALID = 1'b0; Q_READY = 1'b0;
        chk("full_xfer_occ", {30'd0, OCC}, 3);
        chk("full_xfer_q", {23'd0, Q_VALID, Q}, 32'h1A2);
        drain();

        // Bubble collapse
        Q_READY = 1'b0; D_VALID = 1'b1; D = 8'h5C;
        cyc();
        D_VALID = 1'b0;
        chk("bub_s0", {31'd0, Q_VALID}, 0);
        cyc(); chk("bub_s1", {31'd0, Q_VALID}, 0);
        cyc(); chk("bub_s2", {23'd0, Q_VALID, Q}, 32'h15C);
        cyc(); chk("bub_stall", {23'd0, Q_VALID, Q}, 32'h15C);
        chk("bub_occ", {30'd0, OCC}, 1);

        // Preset with two beats in flight, then RST overriding SETN
        D_VALID = 1'b1; D = 8'h66; cyc(); D_VALID = 1'b0;
        chk("pre_set_occ", {30'd0, OCC}, 2);
        SETN = 1'b0; D_VALID = 1'b1; Q_READY = 1'b1;
        cyc();
        chk("set_q", {23'd0, Q_VALID, Q}, 32'h0FF);
        chk("set_occ", {30'd0, OCC}, 0);
        RST = 1'b1;
        cyc();
        chk("rst_over_set_q", {24'd0, Q}, 32'h00);
        RST = 1'b0; SETN = 1'b1; D_VALID = 1'b0;

        // RST coincident with input and output handshakes
        D_VALID = 1'b1;
        D = 8'h77; cyc();
        D = 8'h88; cyc();
        D = 8'h99; cyc();
        chk("pre_rst_qv", {23'd0, Q_VALID, Q}, 32'h177);
        RST = 1'b1; D = 8'hAA;
        cyc();
        RST = 1'b0; D_VALID = 1'b0;
        chk("midrst_occ", {30'd0, OCC}, 0);
        chk("midrst_q", {23'd0, Q_VALID, Q}, 32'h000);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("midrst_quiet", {31'd0, Q_VALID}, 0);
        end

        // Randomized flow-control traffic
        for (int i = 0; i < 200; i++) begin
            D_VALID = ($urandom_range(0, 3) != 0);
            Q_READY = ($urandom_range(0, 2) != 0);
            D = 8'($urandom);
            cyc();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dffrs_pipe.md
DFFRS_PIPE -- requirements
Module: dffrs_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width in bits, minimum 1.
REQ-002 SHALL have parameter DEPTH, default 3: number of register stages, minimum 1.
REQ-003 SHALL have parameter RESET_VAL, default 0 (WIDTH bits): stage data value loaded by RST.
REQ-004 SHALL have parameter SET_VAL, default all-ones (WIDTH bits): stage data value loaded by SETN.
REQ-005 SHALL have port CLK  input  1  single clock; all state updates on rising edge only.
REQ-006 SHALL have port RST  input  1  synchronous, active-high reset; one clock; no asynchronous paths.
REQ-007 SHALL have port SETN  input  1  synchronous active-low preset of all stage data.
REQ-008 SHALL have port D  input  WIDTH  input data beat.
REQ-009 SHALL have port D_VALID  input  1  input beat valid.
REQ-010 SHALL have port D_READY  output  1  pipeline accepts the beat this cycle.
REQ-011 SHALL have port Q  output  WIDTH  data of the last stage, driven regardless of valid.
REQ-012 SHALL have port Q_VALID  output  1  last stage holds a valid beat.
REQ-013 SHALL have port Q_READY  input  1  downstream accepts the beat this cycle.
REQ-014 SHALL have port OCC  output  clog2(DEPTH+1)  count of valid stages.

Function
REQ-015 SHALL implement DEPTH stages s0..s(DEPTH-1); each stage holds WIDTH data and one valid bit; s(DEPTH-1) drives Q/Q_VALID.
REQ-016 SHALL compute move(k) = valid(k) AND (Q_READY for last stage, else NOT valid(k+1) OR move(k+1)); bubbles collapse.
REQ-017 SHALL drive D_READY = NOT valid(0) OR move(0), combinational from Q_READY; no combinational path from D or D_VALID to D_READY.
REQ-018 SHALL treat a transfer as D_VALID AND D_READY on a rising edge; the beat loads into s0.
REQ-019 SHALL treat an output handshake as Q_VALID AND Q_READY; the beat leaves s(DEPTH-1) on that edge.
REQ-020 SHALL advance a beat one stage per cycle when move(k) is true; the stage data is unchanged when move(k) is false.
REQ-021 SHALL present a beat accepted at edge t on Q with Q_VALID=1 after edge t+DEPTH-1 when the pipeline is empty and Q_READY=1 (latency DEPTH cycles to handshake).
REQ-022 SHALL sustain 1 beat/cycle with Q_READY held high, including when full.
REQ-023 SHALL hold Q and Q_VALID stable while Q_VALID=1 and Q_READY=0.
REQ-024 SHALL deassert D_READY when all stages are valid and Q_READY=0 (full).
REQ-025 SHALL accept and emit simultaneously when full and Q_READY=1; OCC is unchanged in that case.
REQ-026 SHALL update OCC each edge by +1 on input transfer only, -1 on output transfer only, and 0 on both or neither; OCC never exceeds DEPTH and never wraps.
REQ-027 SHALL, when SETN=0 and RST=0 on an edge, load every stage data with SET_VAL, clear all valid bits, and set OCC=0; D_READY is don't-care and no beat is accepted.
REQ-028 SHALL give priority RST > SETN > handshake; a handshake coincident with RST or SETN is discarded.
REQ-029 SHALL make DEPTH=1 degenerate to a single registered stage obeying REQ-016..REQ-026.

Reset
REQ-030 SHALL, on an edge with RST=1, load every stage data with RESET_VAL and clear every valid bit; after that edge Q=RESET_VAL, Q_VALID=0, OCC=0, D_READY=1.
REQ-031 SHALL apply RST mid-stream with in-flight beats dropped; no beat is emitted after the reset edge until new input arrives.
REQ-032 SHALL have no output at X after the first RST edge, whatever the D or SETN values.

Verification (WIDTH=8, DEPTH=3, RESET_VAL=0x00, SET_VAL=0xFF)
REQ-033 SHALL check: RST for 1 cycle -> Q=0x00, Q_VALID=0, OCC=0, D_READY=1.
REQ-034 SHALL check: Q_READY=1, beats 0x11, 0x22, 0x33 on consecutive cycles -> Q=0x11 valid 3 cycles after first accept, then 0x22, 0x33 back-to-back.
REQ-035 SHALL check: Q_READY=0, 4 beats offered -> 3 accepted, OCC=3, D_READY=0, Q held at first beat; Q_READY=1 for 1 cycle -> one beat out, the 4th beat accepted the same edge, OCC=3.
REQ-036 SHALL check: bubble collapse: a beat in s0 only, Q_READY=0 -> the beat reaches s2 in 2 cycles and stalls there; OCC=1.
REQ-037 SHALL check: SETN=0 with OCC=2 -> Q=0xFF, Q_VALID=0, OCC=0; SETN=0 together with RST=1 -> Q=0x00.
REQ-038 SHALL check: RST asserted on the same edge as D_VALID=1 and Q_VALID=Q_READY=1 -> no beat accepted or emitted, OCC=0.
